channel_equalizer: RTL
======================

Name: channel_equalizer

Overview:
Receive-side counterpart of the channel gain stage. It removes a flat channel attenuation from a stream of complex baseband samples by multiplying each sample by a programmed inverse gain, then rounds and saturates the result. It sits between the channel/ADC path and the FFT/demapper and uses the same Wishbone-style streaming handshake (CYC/STB/WE/ACK) on both sides. It frames data in symbols of SYM_LEN samples and absorbs downstream back-pressure in an internal output FIFO.

Parameters:
SYM_LEN, 480, samples accepted per frame before ACK_O is blocked.
FIFO_DEPTH, 4, output FIFO entries, power of two, at least 4.
GAIN_FRAC, 12, fractional bits of inv_gain (Q4.12).

Ports:
CLK_I  in  1  clock, all logic on the rising edge.
RST_N_I  in  1  synchronous reset, active-low.
DAT_I  in  32  input sample {Im[31:16], Re[15:0]}, signed Q1.15.
CYC_I  in  1  input frame active.
STB_I  in  1  input strobe.
WE_I  in  1  input write qualifier.
ACK_O  out  1  input accept (combinational).
inv_gain  in  16  unsigned Q4.12 inverse channel gain; sampled at frame start.
DAT_O  out  32  equalised sample {Im, Re}, signed Q1.15.
STB_O  out  1  output strobe.
CYC_O  out  1  output frame active.
WE_O  out  1  equals STB_O.
ACK_I  in  1  downstream accept.
sat_cnt  out  16  saturation event count (see Optional Feature).

Behaviour:
- Reset: one clock; the reset is synchronous and active-low. RST_N_I=0 at a rising edge clears DAT_O=0, STB_O=0, CYC_O=0, sat_cnt=0, FIFO, pipeline valids, sample counter, gain register=0, and state=IDLE. Reset mid-frame discards all data in flight.
- Input accept: in_val = CYC_I & STB_I & WE_I. ACK_O = in_val & (state==RUN or the IDLE->RUN cycle) & (fifo_count + inflight < FIFO_DEPTH). A transfer occurs on a cycle with ACK_O=1.
- Frame start: when CYC_I rises (registered edge detect), latch inv_gain into gain_r, clear sample_cnt and go to RUN. gain_r is held for the whole frame.
- Pipeline, fixed 3 cycles from accept to FIFO write:
  - S1 registers the sample.
  - S2 computes the signed 16 x signed-17 products Re*{0,gain_r} and Im*{0,gain_r}, giving 33-bit results.
  - S3 adds 2^(GAIN_FRAC-1), arithmetic-shifts right by GAIN_FRAC, and saturates to [-32768, 32767].
  - inflight = number of valid stages (0 to 3).
- Output: STB_O=1 whenever the FIFO is non-empty. DAT_O is the FIFO head. The head is popped when STB_O & ACK_I. DAT_O holds stable while STB_O=1 and ACK_I=0. Order is preserved and no sample is lost or duplicated.
- FIFO: a simultaneous push and pop leaves fifo_count unchanged. Push into a full FIFO cannot occur, because the credit check in ACK_O prevents it.
- State machine:
  - IDLE -> RUN on CYC_I rising edge.
  - RUN -> HOLD when sample_cnt reaches SYM_LEN; the SYM_LEN-th accept causes the transition, and ACK_O=0 in HOLD.
  - RUN or HOLD -> DRAIN when CYC_I=0.
  - DRAIN -> IDLE when the pipeline and FIFO are both empty.
  - DRAIN -> RUN if CYC_I rises again.
- CYC_O: set the cycle after the first FIFO write of a frame. Cleared when CYC_I=0, the pipeline is empty and the FIFO is empty.

Optional Feature:
SAT_CNT_EN defined:
- sat_cnt increments by 1 per output component that saturated in S3 (0, 1 or 2 per sample) and saturates at 0xFFFF.
- It clears at reset and at each frame start.
SAT_CNT_EN undefined:
- sat_cnt is tied to 0 and the counter logic is not built.

Test Plan:
- Unity gain: inv_gain=0x1000, 16 samples DAT_I=0x1234_8001, ACK_I=1 -> DAT_O=0x1234_8001 on each sample, first STB_O 3-4 cycles after first ACK_O, no gaps.
- Inverse of 0.8: inv_gain=0x1400, DAT_I={0x4CCD,0x6666} -> DAT_O Re=0x7FFF (saturated from 32768 after rounding), Im=0x6000. With SAT_CNT_EN, sat_cnt=1.
- Negative and saturation edges: inv_gain=0x2000 with Re=0xC000 -> 0x8000 (no saturation). Re=0x4000 -> 0x7FFF. Re=0x8000 -> 0x8000 (saturated).
- Back-pressure: stream 20 samples 0..19 with ACK_I=0 for cycles 5-14 -> ACK_O drops once FIFO plus inflight reaches 4, and DAT_O delivers 0..19 in order with no loss.
- Frame limit: 500 samples offered in one CYC_I frame -> exactly 480 ACK_O pulses, then ACK_O=0. After CYC_I low then high, acceptance resumes with the new inv_gain.
- Reset mid-frame: RST_N_I=0 for 1 cycle with 3 samples in the FIFO -> next cycle STB_O=0, CYC_O=0, DAT_O=0, and the following frame's output contains no stale data.

Source files
------------

// File: rtl/channel_equalizer.sv
// channel_equalizer
//   Receive-side flat-gain equaliser. Each complex sample {Im, Re} (signed
//   Q1.15) is multiplied by an unsigned Q4.12 inverse gain. The product is
//   rounded half-up, saturated back to Q1.15 and queued in a small output
//   FIFO. Samples are framed by CYC_I and at most SYM_LEN of them are accepted
//   per frame.
//
//   Optional feature: define SAT_CNT_EN to build the saturation event counter
//   driven on sat_cnt. Without it, sat_cnt is tied to zero.
//
// Ports
//   CLK_I     clock, rising edge
//   RST_N_I   synchronous reset, active-low
//   DAT_I     input sample {Im[31:16], Re[15:0]}
//   CYC_I     input frame active
//   STB_I     input strobe
//   WE_I      input write qualifier
//   ACK_O     input accept (combinational)
//   inv_gain  Q4.12 inverse gain, latched at frame start
//   DAT_O     equalised sample {Im, Re}, zero while the FIFO is empty
//   STB_O     output strobe (FIFO non-empty)
//   CYC_O     output frame active
//   WE_O      copy of STB_O
//   ACK_I     downstream accept
//   sat_cnt   saturated-component count for the current frame
module channel_equalizer #(
  parameter int SYM_LEN    = 480,
  parameter int FIFO_DEPTH = 4,
  parameter int GAIN_FRAC  = 12,
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int STAGES     = 3
) (
  input  logic                  CLK_I,
  input  logic                  RST_N_I,
  input  logic [2*DATA_W-1:0]   DAT_I,
  input  logic                  CYC_I,
  input  logic                  STB_I,
  input  logic                  WE_I,
  output logic                  ACK_O,
  input  logic [COEF_W-1:0]     inv_gain,
  output logic [2*DATA_W-1:0]   DAT_O,
  output logic                  STB_O,
  output logic                  CYC_O,
  output logic                  WE_O,
  input  logic                  ACK_I,
  output logic [15:0]           sat_cnt
);

  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + STAGES + 1);
  localparam int SC_W   = $clog2(SYM_LEN + 1);

  localparam logic signed [PROD_W:0] RND     = (PROD_W+1)'(1) << (GAIN_FRAC - 1);
  localparam logic signed [PROD_W:0] SAT_MAX = (PROD_W+1)'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [PROD_W:0] SAT_MIN = ~SAT_MAX;

  // Round half-up, drop GAIN_FRAC fraction bits, clamp to DATA_W.
  // MSB of the result flags that clamping took place.
  function automatic logic [DATA_W:0] round_sat(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W:0] r;
    r = {p[PROD_W-1], p};
    r = r + RND;
    r = r >>> GAIN_FRAC;
    if (r > SAT_MAX)      round_sat = {1'b1, SAT_MAX[DATA_W-1:0]};
    else if (r < SAT_MIN) round_sat = {1'b1, SAT_MIN[DATA_W-1:0]};
    else                  round_sat = {1'b0, r[DATA_W-1:0]};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DRAIN} state_t;
  state_t state_q, state_d;

  logic                 cyc_d;
  logic                 cyc_rise, frame_start, in_val, run_ok;
  logic [COEF_W-1:0]    gain_r;
  logic signed [COEF_W:0] gain_s;
  logic [SC_W-1:0]      sample_cnt;

  logic                 vld_p0, vld_p1, vld_p2;
  logic signed [DATA_W-1:0] re_p0, im_p0, re_p2, im_p2;
  logic signed [PROD_W-1:0] re_p1, im_p1;
  logic [DATA_W:0]      rs_re, rs_im;

  logic [2*DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          fifo_count;
  logic [CNT_W-1:0]     credit;
  logic                 push, pop, fifo_empty, pipe_empty;
  logic                 cyc_o_q;

  assign in_val      = CYC_I & STB_I & WE_I;
  assign cyc_rise    = CYC_I & ~cyc_d;
  assign frame_start = cyc_rise & ((state_q == IDLE) | (state_q == DRAIN));
  assign run_ok      = (state_q == RUN) | frame_start;
  assign pipe_empty  = ~(vld_p0 | vld_p1 | vld_p2);
  assign fifo_empty  = (fifo_count == '0);
  // Every sample in the pipe holds a FIFO slot in reserve, so a push can
  // never find the FIFO full.
  assign credit      = CNT_W'(fifo_count) + CNT_W'(vld_p0) + CNT_W'(vld_p1) + CNT_W'(vld_p2);
  assign ACK_O       = in_val & run_ok & (credit < CNT_W'(FIFO_DEPTH));
  assign gain_s      = $signed({1'b0, gain_r});
  assign push        = vld_p2;
  assign pop         = STB_O & ACK_I;
  assign rs_re       = round_sat(re_p1);
  assign rs_im       = round_sat(im_p1);

  assign STB_O = ~fifo_empty;
  assign WE_O  = STB_O;
  assign CYC_O = cyc_o_q;
  assign DAT_O = fifo_empty ? '0 : mem[rd_ptr];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (cyc_rise) state_d = RUN;
      RUN: begin
        if (!CYC_I) state_d = DRAIN;
        else if (ACK_O && (sample_cnt == SC_W'(SYM_LEN - 1))) state_d = HOLD;
      end
      HOLD:  if (!CYC_I) state_d = DRAIN;
      DRAIN: begin
        if (cyc_rise) state_d = RUN;
        else if (pipe_empty && fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      state_q    <= IDLE;
      cyc_d      <= 1'b0;
      gain_r     <= '0;
      sample_cnt <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      cyc_o_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_d   <= CYC_I;
      if (frame_start) begin
        gain_r     <= inv_gain;
        sample_cnt <= ACK_O ? SC_W'(1) : '0;
      end else if (ACK_O) begin
        sample_cnt <= sample_cnt + SC_W'(1);
      end
      vld_p0 <= ACK_O;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (!CYC_I && pipe_empty && fifo_empty) cyc_o_q <= 1'b0;
      else if (push)                          cyc_o_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    // ---- p0: register accepted sample
    if (ACK_O) begin
      re_p0 <= DAT_I[DATA_W-1:0];
      im_p0 <= DAT_I[2*DATA_W-1:DATA_W];
    end
    // ---- p1: full-precision products
    if (vld_p0) begin
      re_p1 <= PROD_W'(re_p0) * PROD_W'(gain_s);
      im_p1 <= PROD_W'(im_p0) * PROD_W'(gain_s);
    end
    // ---- p2: rounded and saturated result
    if (vld_p1) begin
      re_p2 <= rs_re[DATA_W-1:0];
      im_p2 <= rs_im[DATA_W-1:0];
    end
    // ---- FIFO write
    if (push) mem[wr_ptr] <= {im_p2, re_p2};
  end

`ifdef SAT_CNT_EN
  logic [15:0] sat_q;
  logic [1:0]  nsat;
  logic [16:0] sat_sum;

  assign nsat    = vld_p1 ? ({1'b0, rs_re[DATA_W]} + {1'b0, rs_im[DATA_W]}) : 2'd0;
  assign sat_sum = {1'b0, sat_q} + 17'(nsat);

  always_ff @(posedge CLK_I) begin
    if (!RST_N_I)        sat_q <= '0;
    else if (frame_start) sat_q <= '0;
    else if (sat_sum[16]) sat_q <= 16'hFFFF;
    else                  sat_q <= sat_sum[15:0];
  end

  assign sat_cnt = sat_q;
`else
  logic unused_sat;
  assign unused_sat = rs_re[DATA_W] ^ rs_im[DATA_W];
  assign sat_cnt    = '0;
`endif

endmodule
